// File: rtl/acsp_pkg.sv
// Shared definitions for the sample readout block.
//   readout_state_t : readout FSM state encoding
//   PAD_BYTE        : byte transmitted when the sample FIFO runs dry
//   COUNT_W         : width of the read_count / remaining counter
package acsp_pkg;

    localparam int unsigned COUNT_W  = 16;
    localparam logic [7:0]  PAD_BYTE = 8'h00;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_DATA,
        SEND,
        WAIT_TX_HI,
        WAIT_TX_LO,
        FINISH
    } readout_state_t;

endpackage

// File: rtl/sample_readout_if.sv
// Controller / FIFO / UART signal bundle for sample_readout.
//   master : controller, FIFO and UART side (drives start, abort, read_count,
//            fifo_empty, fifo_data, fifo_valid, tx_busy)
//   slave  : sample_readout (drives fifo_rd_en, tx_en, tx_data, busy, done
//            and, with READOUT_TIMEOUT_EN defined, timeout)
// Macro READOUT_TIMEOUT_EN adds the one-bit timeout pulse.
interface sample_readout_if
    import acsp_pkg::*;
#(
    parameter int unsigned SAMPLE_WIDTH = 8
);
    logic                    start;
    logic                    abort;
    logic [COUNT_W-1:0]      read_count;
    logic                    fifo_empty;
    logic                    fifo_rd_en;
    logic [SAMPLE_WIDTH-1:0] fifo_data;
    logic                    fifo_valid;
    logic                    tx_busy;
    logic                    tx_en;
    logic [SAMPLE_WIDTH-1:0] tx_data;
    logic                    busy;
    logic                    done;
`ifdef READOUT_TIMEOUT_EN
    logic                    timeout;

    modport master (
        output start, abort, read_count, fifo_empty, fifo_data, fifo_valid, tx_busy,
        input  fifo_rd_en, tx_en, tx_data, busy, done, timeout
    );

    modport slave (
        input  start, abort, read_count, fifo_empty, fifo_data, fifo_valid, tx_busy,
        output fifo_rd_en, tx_en, tx_data, busy, done, timeout
    );
`else
    modport master (
        output start, abort, read_count, fifo_empty, fifo_data, fifo_valid, tx_busy,
        input  fifo_rd_en, tx_en, tx_data, busy, done
    );

    modport slave (
        input  start, abort, read_count, fifo_empty, fifo_data, fifo_valid, tx_busy,
        output fifo_rd_en, tx_en, tx_data, busy, done
    );
`endif

endinterface

// File: rtl/sample_readout.sv
// Streams read_count samples from the sample FIFO to the UART, one byte per
// transmit handshake, padding with PAD_BYTE when the FIFO is empty.
//   clock, reset_n : system clock, asynchronous active-low reset
//   bus (slave)    : start/abort/read_count from the controller, FIFO pop
//                    interface, UART transmit interface, busy/done status
// Macro READOUT_TIMEOUT_EN adds a watchdog that abandons a readout stuck in a
// wait state for 65535 cycles and pulses bus.timeout.
module sample_readout
    import acsp_pkg::*;
#(
    parameter int unsigned SAMPLE_WIDTH = 8
) (
    input  logic            clock,
    input  logic            reset_n,
    sample_readout_if.slave bus
);

    readout_state_t          state, state_n;
    logic [COUNT_W-1:0]      remaining, remaining_n;
    logic [SAMPLE_WIDTH-1:0] tx_data_q, tx_data_n;
    logic                    fifo_rd_en_q, fifo_rd_en_n;
    logic                    tx_en_q, tx_en_n;
    logic                    busy_q;
    logic                    done_q, done_n;

`ifdef READOUT_TIMEOUT_EN
    localparam int unsigned WDOG_W = 16;
    // Watchdog holds the number of cycles already spent in the current state;
    // this value marks the 65535th cycle.
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(16'hFFFE);

    logic [WDOG_W-1:0] wdog, wdog_n;
    logic              timeout_q, timeout_n;
`endif

    // State and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            remaining    <= '0;
            tx_data_q    <= '0;
            fifo_rd_en_q <= 1'b0;
            tx_en_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef READOUT_TIMEOUT_EN
            wdog         <= '0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            state        <= state_n;
            remaining    <= remaining_n;
            tx_data_q    <= tx_data_n;
            fifo_rd_en_q <= fifo_rd_en_n;
            tx_en_q      <= tx_en_n;
            busy_q       <= (state_n != IDLE);
            done_q       <= done_n;
`ifdef READOUT_TIMEOUT_EN
            wdog         <= wdog_n;
            timeout_q    <= timeout_n;
`endif
        end
    end

    // Next state and next registered outputs
    always_comb begin
        state_n      = state;
        remaining_n  = remaining;
        tx_data_n    = tx_data_q;
        fifo_rd_en_n = 1'b0;
        tx_en_n      = 1'b0;
        done_n       = 1'b0;
`ifdef READOUT_TIMEOUT_EN
        timeout_n    = 1'b0;
        wdog_n       = wdog;
`endif

        case (state)
            IDLE: begin
                if (bus.start) begin
                    remaining_n = bus.read_count;
                    state_n     = (bus.read_count == '0) ? FINISH : FETCH;
                end
            end
            FETCH: begin
                if (!bus.fifo_empty) begin
                    fifo_rd_en_n = 1'b1;
                    state_n      = WAIT_DATA;
                end else begin
                    tx_data_n = SAMPLE_WIDTH'(PAD_BYTE);
                    state_n   = SEND;
                end
            end
            WAIT_DATA: begin
                if (bus.fifo_valid) begin
                    tx_data_n = bus.fifo_data;
                    state_n   = SEND;
                end
            end
            SEND: begin
                tx_en_n = 1'b1;
                state_n = WAIT_TX_HI;
            end
            WAIT_TX_HI: begin
                if (bus.tx_busy) begin
                    state_n = WAIT_TX_LO;
                end
            end
            WAIT_TX_LO: begin
                if (!bus.tx_busy) begin
                    // remaining is at least 1 here; the guard keeps it from wrapping
                    if (remaining != '0) begin
                        remaining_n = remaining - COUNT_W'(1);
                    end
                    state_n = (remaining > COUNT_W'(1)) ? FETCH : FINISH;
                end
            end
            FINISH: begin
                done_n  = 1'b1;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

`ifdef READOUT_TIMEOUT_EN
        // Abandon a readout stuck waiting on the FIFO or the UART
        if (((state == WAIT_DATA) || (state == WAIT_TX_HI) || (state == WAIT_TX_LO)) &&
            (wdog == WDOG_LAST)) begin
            state_n   = IDLE;
            tx_data_n = tx_data_q;
            timeout_n = 1'b1;
        end
`endif

        // Abort overrides everything, including a start seen in IDLE
        if (bus.abort) begin
            state_n      = IDLE;
            remaining_n  = remaining;
            fifo_rd_en_n = 1'b0;
            tx_en_n      = 1'b0;
            done_n       = 1'b0;
`ifdef READOUT_TIMEOUT_EN
            timeout_n    = 1'b0;
`endif
        end

`ifdef READOUT_TIMEOUT_EN
        // Restart on every state change, saturate otherwise
        if (state_n != state) begin
            wdog_n = '0;
        end else if (wdog != '1) begin
            wdog_n = wdog + WDOG_W'(1);
        end
`endif
    end

    assign bus.fifo_rd_en = fifo_rd_en_q;
    assign bus.tx_en      = tx_en_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
`ifdef READOUT_TIMEOUT_EN
    assign bus.timeout    = timeout_q;
`endif

endmodule

// File: tb/tb_sample_readout.sv
// Self-checking bench for sample_readout: FIFO responder with random 1-4 cycle
// read latency, UART model holding tx_busy for a fixed number of cycles, and a
// scoreboard of expected transmit bytes popped on every tx_en pulse.
module tb_sample_readout;

    localparam int unsigned SW = 8;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    always #5 clock = ~clock;

    sample_readout_if #(.SAMPLE_WIDTH(SW)) bus ();

    sample_readout #(.SAMPLE_WIDTH(SW)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [SW-1:0] fifo_q[$];
    logic [SW-1:0] exp_q[$];

    int tx_cnt     = 0;
    int rd_cnt     = 0;
    int done_cnt   = 0;
    int busy_len   = 10;
    bit uart_stuck = 1'b0;

    int            pend_cnt   = 0;
    logic [SW-1:0] pend_data  = '0;
    int            uart_cnt   = 0;
    logic [SW-1:0] tx_latched = '0;
    logic [SW-1:0] exp_byte   = '0;

    // FIFO responder, UART model and scoreboard, all sampled on the falling edge
    initial begin
        bus.fifo_empty = 1'b1;
        bus.fifo_valid = 1'b0;
        bus.fifo_data  = '0;
        bus.tx_busy    = 1'b0;
        forever begin
            @(negedge clock);
            bus.fifo_valid = 1'b0;
            if (pend_cnt > 0) begin
                pend_cnt = pend_cnt - 1;
                if (pend_cnt == 0) begin
                    bus.fifo_valid = 1'b1;
                    bus.fifo_data  = pend_data;
                end
            end
            if (bus.fifo_rd_en === 1'b1) begin
                rd_cnt = rd_cnt + 1;
                pend_data = (fifo_q.size() > 0) ? fifo_q.pop_front() : 8'hEE;
                pend_cnt  = int'($urandom_range(4, 1));
            end
            bus.fifo_empty = (fifo_q.size() == 0);

            if (uart_cnt > 0) begin
                uart_cnt = uart_cnt - 1;
                if (uart_cnt == 0) begin
                    bus.tx_busy = 1'b0;
                    checks = checks + 1;
                    if (bus.tx_data !== tx_latched) begin
                        errors = errors + 1;
                        $display("FAIL tx_data_stable: got %h, required %h", bus.tx_data, tx_latched);
                    end
                end
            end
            if (bus.tx_en === 1'b1) begin
                tx_cnt = tx_cnt + 1;
                checks = checks + 1;
                if (exp_q.size() == 0) begin
                    errors = errors + 1;
                    $display("FAIL tx_unexpected: got tx_en with %h, required no transmit", bus.tx_data);
                end else begin
                    exp_byte = exp_q.pop_front();
                    if (bus.tx_data !== exp_byte) begin
                        errors = errors + 1;
                        $display("FAIL tx_byte: got %h, required %h", bus.tx_data, exp_byte);
                    end
                end
                tx_latched = bus.tx_data;
                if (!uart_stuck) begin
                    bus.tx_busy = 1'b1;
                    uart_cnt    = busy_len;
                end
            end
            if (bus.done === 1'b1) begin
                done_cnt = done_cnt + 1;
            end
        end
    end

    task automatic pulse_start(input logic [15:0] rc);
        @(posedge clock);
        #1;
        bus.start      = 1'b1;
        bus.read_count = rc;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clock);
            if (bus.busy === 1'b0) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        #1;
        checks = checks + 5;
        if (bus.busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b, required 0", bus.busy); end
        if (bus.done !== 1'b0)       begin errors++; $display("FAIL reset_done: got %b, required 0", bus.done); end
        if (bus.tx_en !== 1'b0)      begin errors++; $display("FAIL reset_tx_en: got %b, required 0", bus.tx_en); end
        if (bus.fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b, required 0", bus.fifo_rd_en); end
        if (bus.tx_data !== '0)      begin errors++; $display("FAIL reset_tx_data: got %h, required 00", bus.tx_data); end
    endtask

    task automatic test_basic;
        int tx0 = tx_cnt;
        int rd0 = rd_cnt;
        int d0  = done_cnt;
        bit to;
        fifo_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        exp_q  = '{8'h11, 8'h22, 8'h33, 8'h44};
        pulse_start(16'd4);
        @(negedge clock);
        checks++;
        if (bus.fifo_rd_en !== 1'b0) begin errors++; $display("FAIL basic_rd_latency1: got %b, required 0", bus.fifo_rd_en); end
        @(negedge clock);
        checks++;
        if (bus.fifo_rd_en !== 1'b1) begin errors++; $display("FAIL basic_rd_latency2: got %b, required 1", bus.fifo_rd_en); end
        wait_idle(2000, to);
        checks = checks + 5;
        if (to)                 begin errors++; $display("FAIL basic_finish: got busy after 2000 cycles, required idle"); end
        if (tx_cnt - tx0 != 4)  begin errors++; $display("FAIL basic_tx_count: got %0d, required 4", tx_cnt - tx0); end
        if (rd_cnt - rd0 != 4)  begin errors++; $display("FAIL basic_rd_count: got %0d, required 4", rd_cnt - rd0); end
        if (done_cnt - d0 != 1) begin errors++; $display("FAIL basic_done_count: got %0d, required 1", done_cnt - d0); end
        if (exp_q.size() != 0)  begin errors++; $display("FAIL basic_scoreboard: got %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_pad;
        int tx0 = tx_cnt;
        int rd0 = rd_cnt;
        int d0  = done_cnt;
        bit to;
        fifo_q = '{8'hA5};
        exp_q  = '{8'hA5, 8'h00, 8'h00};
        pulse_start(16'd3);
        wait_idle(2000, to);
        checks = checks + 5;
        if (to)                 begin errors++; $display("FAIL pad_finish: got busy after 2000 cycles, required idle"); end
        if (tx_cnt - tx0 != 3)  begin errors++; $display("FAIL pad_tx_count: got %0d, required 3", tx_cnt - tx0); end
        if (rd_cnt - rd0 != 1)  begin errors++; $display("FAIL pad_rd_count: got %0d, required 1", rd_cnt - rd0); end
        if (done_cnt - d0 != 1) begin errors++; $display("FAIL pad_done_count: got %0d, required 1", done_cnt - d0); end
        if (exp_q.size() != 0)  begin errors++; $display("FAIL pad_scoreboard: got %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_zero;
        int tx0 = tx_cnt;
        int rd0 = rd_cnt;
        int d0  = done_cnt;
        exp_q.delete();
        pulse_start(16'd0);
        @(negedge clock);
        checks = checks + 2;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL zero_busy: got %b, required 1", bus.busy); end
        if (bus.done !== 1'b0) begin errors++; $display("FAIL zero_done_early: got %b, required 0", bus.done); end
        @(negedge clock);
        checks = checks + 2;
        if (bus.done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b, required 1", bus.done); end
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL zero_idle: got %b, required 0", bus.busy); end
        repeat (4) @(negedge clock);
        checks = checks + 3;
        if (tx_cnt - tx0 != 0)  begin errors++; $display("FAIL zero_tx_count: got %0d, required 0", tx_cnt - tx0); end
        if (rd_cnt - rd0 != 0)  begin errors++; $display("FAIL zero_rd_count: got %0d, required 0", rd_cnt - rd0); end
        if (done_cnt - d0 != 1) begin errors++; $display("FAIL zero_done_count: got %0d, required 1", done_cnt - d0); end
    endtask

    task automatic test_abort;
        int tx0 = tx_cnt;
        int rd0 = rd_cnt;
        int d0  = done_cnt;
        bit to;
        fifo_q = '{8'h51, 8'h52, 8'h53, 8'h54, 8'h55};
        exp_q  = '{8'h51, 8'h52};
        pulse_start(16'd5);
        to = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clock);
            if (tx_cnt - tx0 == 2) begin
                to = 1'b0;
                break;
            end
        end
        checks++;
        if (to) begin errors++; $display("FAIL abort_reach_second: got %0d transmits, required 2", tx_cnt - tx0); end
        repeat (3) @(negedge clock);
        @(posedge clock);
        #1 bus.abort = 1'b1;
        @(posedge clock);
        #1 bus.abort = 1'b0;
        @(negedge clock);
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b, required 0", bus.busy); end
        repeat (40) @(negedge clock);
        checks = checks + 3;
        if (tx_cnt - tx0 != 2)  begin errors++; $display("FAIL abort_tx_count: got %0d, required 2", tx_cnt - tx0); end
        if (rd_cnt - rd0 != 2)  begin errors++; $display("FAIL abort_rd_count: got %0d, required 2", rd_cnt - rd0); end
        if (done_cnt - d0 != 0) begin errors++; $display("FAIL abort_done_count: got %0d, required 0", done_cnt - d0); end
        fifo_q.delete();
        exp_q.delete();

        // abort and start together in IDLE: start is dropped
        @(posedge clock);
        #1;
        bus.abort      = 1'b1;
        bus.start      = 1'b1;
        bus.read_count = 16'd2;
        @(posedge clock);
        #1;
        bus.abort = 1'b0;
        bus.start = 1'b0;
        @(negedge clock);
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_start_same: got busy %b, required 0", bus.busy); end

        // a fresh start is accepted afterwards
        fifo_q = '{8'h5A};
        exp_q  = '{8'h5A};
        pulse_start(16'd1);
        wait_idle(2000, to);
        checks = checks + 3;
        if (to)                 begin errors++; $display("FAIL abort_restart_finish: got busy, required idle"); end
        if (tx_cnt - tx0 != 3)  begin errors++; $display("FAIL abort_restart_tx: got %0d, required 3", tx_cnt - tx0); end
        if (done_cnt - d0 != 1) begin errors++; $display("FAIL abort_restart_done: got %0d, required 1", done_cnt - d0); end
    endtask

    task automatic test_reset_mid;
        int tx0 = tx_cnt;
        int rd0 = rd_cnt;
        int d0  = done_cnt;
        bit to;
        fifo_q = '{8'h61, 8'h62};
        exp_q.delete();
        pulse_start(16'd2);
        to = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (bus.fifo_rd_en === 1'b1) begin
                to = 1'b0;
                break;
            end
        end
        checks++;
        if (to) begin errors++; $display("FAIL rstmid_reach_wait: got no fifo_rd_en, required one"); end
        // mid-cycle, well away from any clock edge
        #2 reset_n = 1'b0;
        #1;
        checks = checks + 5;
        if (bus.busy !== 1'b0)       begin errors++; $display("FAIL rstmid_busy: got %b, required 0", bus.busy); end
        if (bus.done !== 1'b0)       begin errors++; $display("FAIL rstmid_done: got %b, required 0", bus.done); end
        if (bus.tx_en !== 1'b0)      begin errors++; $display("FAIL rstmid_tx_en: got %b, required 0", bus.tx_en); end
        if (bus.fifo_rd_en !== 1'b0) begin errors++; $display("FAIL rstmid_rd_en: got %b, required 0", bus.fifo_rd_en); end
        if (bus.tx_data !== '0)      begin errors++; $display("FAIL rstmid_tx_data: got %h, required 00", bus.tx_data); end
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        repeat (12) @(negedge clock);
        checks = checks + 3;
        if (bus.busy !== 1'b0)  begin errors++; $display("FAIL rstmid_idle: got %b, required 0", bus.busy); end
        if (done_cnt - d0 != 0) begin errors++; $display("FAIL rstmid_done_count: got %0d, required 0", done_cnt - d0); end
        if (tx_cnt - tx0 != 0)  begin errors++; $display("FAIL rstmid_tx_count: got %0d, required 0", tx_cnt - tx0); end
        fifo_q.delete();

        // repeated start during a readout is ignored
        tx0 = tx_cnt;
        rd0 = rd_cnt;
        d0  = done_cnt;
        fifo_q = '{8'h31, 8'h32, 8'h33};
        exp_q  = '{8'h31, 8'h32, 8'h33};
        pulse_start(16'd3);
        repeat (5) @(negedge clock);
        pulse_start(16'd7);
        wait_idle(3000, to);
        checks = checks + 5;
        if (to)                 begin errors++; $display("FAIL restart_finish: got busy, required idle"); end
        if (tx_cnt - tx0 != 3)  begin errors++; $display("FAIL restart_tx_count: got %0d, required 3", tx_cnt - tx0); end
        if (rd_cnt - rd0 != 3)  begin errors++; $display("FAIL restart_rd_count: got %0d, required 3", rd_cnt - rd0); end
        if (done_cnt - d0 != 1) begin errors++; $display("FAIL restart_done_count: got %0d, required 1", done_cnt - d0); end
        if (exp_q.size() != 0)  begin errors++; $display("FAIL restart_scoreboard: got %0d left, required 0", exp_q.size()); end
    endtask

`ifdef READOUT_TIMEOUT_EN
    task automatic test_timeout;
        int d0 = done_cnt;
        int cyc = 0;
        bit to;
        uart_stuck = 1'b1;
        fifo_q = '{8'h77};
        exp_q  = '{8'h77};
        pulse_start(16'd1);
        to = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (bus.tx_en === 1'b1) begin
                to = 1'b0;
                break;
            end
        end
        checks++;
        if (to) begin errors++; $display("FAIL timeout_tx_en: got no tx_en, required one"); end
        to = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            @(negedge clock);
            cyc++;
            if (bus.timeout === 1'b1) begin
                to = 1'b0;
                break;
            end
        end
        checks = checks + 4;
        if (to)                 begin errors++; $display("FAIL timeout_pulse: got none in 70000 cycles, required one"); end
        if (cyc != 65535)       begin errors++; $display("FAIL timeout_cycles: got %0d, required 65535", cyc); end
        if (bus.busy !== 1'b0)  begin errors++; $display("FAIL timeout_idle: got %b, required 0", bus.busy); end
        if (done_cnt - d0 != 0) begin errors++; $display("FAIL timeout_done: got %0d, required 0", done_cnt - d0); end
        uart_stuck = 1'b0;
    endtask
`endif

    initial begin
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.read_count = '0;
        reset_n        = 1'b0;
        repeat (3) @(posedge clock);
        test_reset;
        #1 reset_n = 1'b1;
        repeat (2) @(negedge clock);
        test_reset;
        test_basic;
        test_pad;
        test_zero;
        test_abort;
        test_reset_mid;
`ifdef READOUT_TIMEOUT_EN
        test_timeout;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
